// File: rtl/alu_core_pkg.sv
// alu_core_pkg
//   Shared opcode encodings for the ALU core and its sub-modules.
//   alu_op_e     : named 5-bit opcodes with fixed encodings
//   OP_SHIFT_PFX : alu_op[4:2] prefix selecting the barrel shifter;
//                  alu_op[1] = direction (1 = right), alu_op[0] = arithmetic
package alu_core_pkg;

    typedef enum logic [4:0] {
        OP_PASS  = 5'b00000,
        OP_ADDC  = 5'b00001,
        OP_AND   = 5'b00010,
        OP_XOR   = 5'b00011,
        OP_ADD_A = 5'b00101,
        OP_ADD_B = 5'b10101
    } alu_op_e;

    localparam logic [2:0] OP_SHIFT_PFX = 3'b010;

    // True when the opcode belongs to the shift group (010xx).
    function automatic logic is_shift(input logic [4:0] op);
        return (op[4:2] == OP_SHIFT_PFX);
    endfunction

endpackage

// File: rtl/alu_core_shifter.sv
// alu_core_shifter
//   Five-stage logarithmic barrel shifter built from 2:1 muxes.
//   in    : value to shift
//   shamt : shift amount, 0..31 (0 passes the value through)
//   dir   : 0 = left, 1 = right
//   arith : 1 = sign-fill on right shifts; left shifts always zero-fill
//   out   : shifted value
module alu_core_shifter
    import alu_core_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic [4:0]       shamt,
    input  logic             dir,
    input  logic             arith,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] stage [0:5];
    logic             fill;

    // Fill bit only matters for right shifts, so no need to gate on dir.
    assign fill     = arith & in[WIDTH-1];
    assign stage[0] = in;

    for (genvar i = 0; i < 5; i++) begin : g_stage
        localparam int unsigned SH = 1 << i;
        assign stage[i+1] = !shamt[i] ? stage[i]
                          : dir       ? {{SH{fill}}, stage[i][WIDTH-1:SH]}
                                      : {stage[i][WIDTH-1-SH:0], {SH{1'b0}}};
    end

    assign out = stage[5];

endmodule

// File: rtl/alu_core.sv
// alu_core
//   Single-cycle registered ALU: operand select, adder, logic ops and a
//   barrel shifter, with result and flags captured on the rising clock.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset (result/carry/sign 0, zero 1)
//   a, b    : signed operands
//   alu_sel : 0 = operands (a, b), 1 = operands (1, ~b)
//   alu_op  : operation code (see alu_core_pkg)
//   result  : registered result
//   carry   : registered adder carry-out, loaded only by OP_ADDC
//   zero    : registered flag, result == 0
//   sign    : registered flag, result MSB
module alu_core
    import alu_core_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             alu_sel,
    input  logic [4:0]       alu_op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             sign
);

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] shift_out;
    logic [WIDTH-1:0] next_result;
    logic             next_carry;

    assign x = alu_sel ? WIDTH'(1) : a;
    assign y = alu_sel ? ~b : b;

    // The adder deliberately works on the raw a/b, not the selected operands.
    assign sum_ext = {1'b0, a} + {1'b0, b};

    alu_core_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .in    (x),
        .shamt (y[4:0]),
        .dir   (alu_op[1]),
        .arith (alu_op[0]),
        .out   (shift_out)
    );

    always_comb begin
        next_result = '0;
        next_carry  = carry;
        if (is_shift(alu_op)) begin
            next_result = shift_out;
        end else begin
            case (alu_op)
                OP_PASS:  next_result = x;
                OP_ADDC: begin
                    next_result = sum_ext[WIDTH-1:0];
                    next_carry  = sum_ext[WIDTH];
                end
                OP_ADD_A,
                OP_ADD_B: next_result = sum_ext[WIDTH-1:0];
                OP_AND:   next_result = x & y;
                OP_XOR:   next_result = x ^ y;
                default:  next_result = '0;
            endcase
        end
    end

    // Flags derive from next_result so they stay coherent with result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b1;
            sign   <= 1'b0;
        end else begin
            result <= next_result;
            carry  <= next_carry;
            zero   <= (next_result == '0);
            sign   <= next_result[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;

    typedef struct {
        int          id;
        logic [31:0] r;
        logic        c;
        logic        z;
        logic        s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        alu_sel = 1'b0;
    logic [4:0]  alu_op = '0;
    logic [31:0] result;
    logic        carry;
    logic        zero;
    logic        sign;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    alu_core #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .alu_sel (alu_sel),
        .alu_op  (alu_op),
        .result  (result),
        .carry   (carry),
        .zero    (zero),
        .sign    (sign)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int id,
                         input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s vec%0d got %h expected %h", name, id, got, exp);
        end
    endtask

    // Drive one vector (caller is already at a negedge) and queue its response.
    task automatic drive(input int id, input logic [31:0] va, input logic [31:0] vb,
                         input logic vsel, input logic [4:0] vop,
                         input logic [31:0] er, input logic ec, input logic ez,
                         input logic es);
        exp_t e;
        a = va; b = vb; alu_sel = vsel; alu_op = vop;
        e.id = id; e.r = er; e.c = ec; e.z = ez; e.s = es;
        q.push_back(e);
    endtask

    task automatic issue(input int id, input logic [31:0] va, input logic [31:0] vb,
                         input logic vsel, input logic [4:0] vop,
                         input logic [31:0] er, input logic ec, input logic ez,
                         input logic es);
        @(negedge clk);
        drive(id, va, vb, vsel, vop, er, ec, ez, es);
    endtask

    task automatic check_reset_state(input int id);
        check("rst_result", id, result, 32'h0);
        check("rst_carry",  id, {31'b0, carry}, 32'h0);
        check("rst_zero",   id, {31'b0, zero},  32'h1);
        check("rst_sign",   id, {31'b0, sign},  32'h0);
    endtask

    task automatic drain(input int id);
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain vec%0d pending %0d expected 0", id, q.size());
            q.delete();
        end
    endtask

    // Monitor: outputs are valid every cycle; compare whenever a response is owed.
    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check("result", e.id, result, e.r);
            check("carry",  e.id, {31'b0, carry}, {31'b0, e.c});
            check("zero",   e.id, {31'b0, zero},  {31'b0, e.z});
            check("sign",   e.id, {31'b0, sign},  {31'b0, e.s});
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #1 check_reset_state(0);
        @(negedge clk);
        rst_n = 1'b1;

        //     id  a             b             sel   op        result        c     z     s
        issue( 1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 5'b00001, 32'h00000000, 1'b1, 1'b1, 1'b0);
        issue( 2, 32'h00000002, 32'h00000003, 1'b0, 5'b00101, 32'h00000005, 1'b1, 1'b0, 1'b0);
        issue( 3, 32'h00000001, 32'h00000024, 1'b0, 5'b01000, 32'h00000010, 1'b1, 1'b0, 1'b0);
        issue( 4, 32'h80000000, 32'h00000004, 1'b0, 5'b01011, 32'hF8000000, 1'b1, 1'b0, 1'b1);
        issue( 5, 32'h80000000, 32'h00000004, 1'b0, 5'b01010, 32'h08000000, 1'b1, 1'b0, 1'b0);
        issue( 6, 32'h12345678, 32'hFFFFFFFE, 1'b1, 5'b00010, 32'h00000001, 1'b1, 1'b0, 1'b0);
        issue( 7, 32'h12345678, 32'hFFFFFFFE, 1'b1, 5'b00011, 32'h00000000, 1'b1, 1'b1, 1'b0);
        issue( 8, 32'h00000007, 32'h00000009, 1'b0, 5'b11111, 32'h00000000, 1'b1, 1'b1, 1'b0);
        issue( 9, 32'hDEADBEEF, 32'h00000000, 1'b0, 5'b00000, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1);
        issue(10, 32'h00000001, 32'h00000002, 1'b0, 5'b00001, 32'h00000003, 1'b0, 1'b0, 1'b0);
        issue(11, 32'hFFFFFFFF, 32'h00000002, 1'b0, 5'b10101, 32'h00000001, 1'b0, 1'b0, 1'b0);
        issue(12, 32'hFFFFFFFF, 32'h00000001, 1'b0, 5'b00101, 32'h00000000, 1'b0, 1'b1, 1'b0);
        issue(13, 32'h12345678, 32'h00000020, 1'b0, 5'b01001, 32'h12345678, 1'b0, 1'b0, 1'b0);
        issue(14, 32'h80000001, 32'h00000001, 1'b0, 5'b01001, 32'h00000002, 1'b0, 1'b0, 1'b0);
        issue(15, 32'h80000000, 32'h0000001F, 1'b0, 5'b01011, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
        issue(16, 32'h40000000, 32'h00000002, 1'b0, 5'b01011, 32'h10000000, 1'b0, 1'b0, 1'b0);
        issue(17, 32'h80000000, 32'hFFFFFFFF, 1'b0, 5'b01010, 32'h00000001, 1'b0, 1'b0, 1'b0);
        issue(18, 32'h55555555, 32'h33333333, 1'b0, 5'b00100, 32'h00000000, 1'b0, 1'b1, 1'b0);
        issue(19, 32'h55555555, 32'h33333333, 1'b1, 5'b00000, 32'h00000001, 1'b0, 1'b0, 1'b0);
        issue(20, 32'h00000000, 32'hFFFFFFFC, 1'b1, 5'b01000, 32'h00000008, 1'b0, 1'b0, 1'b0);
        issue(21, 32'h00000000, 32'h00000000, 1'b1, 5'b00011, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1);
        issue(22, 32'h7FFFFFFF, 32'h00000001, 1'b0, 5'b00001, 32'h80000000, 1'b0, 1'b0, 1'b1);
        issue(23, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'b00001, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b1);
        issue(24, 32'hDEADBEEF, 32'h00000000, 1'b0, 5'b00000, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1);
        drain(24);

        // Reset pulse between edges must clear outputs with no clock edge.
        @(negedge clk);
        a = 32'h0000ABCD; b = 32'h0; alu_sel = 1'b0; alu_op = 5'b00000;
        #1 rst_n = 1'b0;
        #1 check_reset_state(25);
        // The pending PASS must not be captured while reset is held.
        @(posedge clk);
        #1 check_reset_state(26);

        // First edge after release captures normally.
        @(negedge clk);
        rst_n = 1'b1;
        drive(27, 32'h00000002, 32'h00000003, 1'b0, 5'b00101, 32'h00000005, 1'b0, 1'b0, 1'b0);
        issue(28, 32'h00000001, 32'hFFFFFFFF, 1'b0, 5'b00001, 32'h00000000, 1'b1, 1'b1, 1'b0);
        drain(28);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached %0d expected finish", checks);
        $fatal(1);
    end

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
- REQ-001 The block SHALL have one parameter: WIDTH, default 32, datapath width; only 32 is required to be supported.
- REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
- REQ-003 Port `clk`: input, 1 bit, rising-edge clock.
- REQ-004 Port `rst_n`: input, 1 bit, asynchronous active-low reset.
- REQ-005 Port `a`: input, 32 bits, signed operand A.
- REQ-006 Port `b`: input, 32 bits, signed operand B.
- REQ-007 Port `alu_sel`: input, 1 bit, operand-select; 0 = (a, b), 1 = (32'd1, ~b).
- REQ-008 Port `alu_op`: input, 5 bits, operation code.
- REQ-009 Port `result`: output, 32 bits, registered result.
- REQ-010 Port `carry`: output, 1 bit, registered adder carry-out.
- REQ-011 Port `zero`: output, 1 bit, registered flag, 1 when `result` == 0.
- REQ-012 Port `sign`: output, 1 bit, registered flag, equal to `result[31]`.

Function
- REQ-013 The selected operands SHALL be X = `alu_sel` ? 32'h00000001 : `a` and Y = `alu_sel` ? ~`b` : `b`.
- REQ-014 The adder SHALL always add the raw `a` + `b` (not X/Y) with carry-in 0, producing a 32-bit sum and a carry-out.
- REQ-015 alu_op 00000 SHALL produce result = X.
- REQ-016 alu_op 00001 SHALL produce result = sum and SHALL load `carry` with the adder carry-out.
- REQ-017 alu_op 00101 and 10101 SHALL produce result = sum with `carry` unchanged.
- REQ-018 alu_op 00010 SHALL produce result = X & Y.
- REQ-019 alu_op 00011 SHALL produce result = X ^ Y.
- REQ-020 alu_op 010xx SHALL produce result = X shifted by Y[4:0].
- REQ-021 For shifts, alu_op[1] SHALL give the direction: 0 = left, 1 = right.
- REQ-022 For shifts, alu_op[0] SHALL select 1 = arithmetic (sign-fill on right shift), 0 = logical (zero-fill).
- REQ-023 A left shift SHALL always zero-fill, regardless of alu_op[0].
- REQ-024 Y[31:5] SHALL be ignored by shifts; shift amount 0 SHALL pass X unchanged.
- REQ-025 Every other alu_op SHALL produce result = 0.
- REQ-026 For every opcode other than 00001, `carry` SHALL hold its previous value.
- REQ-027 `result`, `zero` and `sign` SHALL be updated on every rising `clk` edge, with one-cycle latency from inputs to outputs.
- REQ-028 `zero` and `sign` SHALL be computed from the next-state result, so all three are coherent in the same cycle.
- REQ-029 Arithmetic SHALL wrap modulo 2^32; no overflow flag SHALL be produced.

Reset
- REQ-030 While `rst_n` = 0, `result`, `carry` and `sign` SHALL be 0 immediately, independent of `clk`.
- REQ-031 While `rst_n` = 0, `zero` SHALL be 1, consistent with result = 0.
- REQ-032 After `rst_n` deasserts, the first rising edge SHALL capture normally.
- REQ-033 A reset asserted mid-operation SHALL discard the pending result.

Structure
- REQ-034 Opcode constants (PASS, ADDC, ADD_A, ADD_B, AND, XOR, SHIFT prefix 010) SHALL live in a shared package `alu_core_pkg`.
- REQ-035 The barrel shifter SHALL be one sub-module, `alu_core_shifter`: 5 stages of 2:1 muxes, with inputs in, shamt[4:0], dir, arith.
- REQ-036 The adder and operand muxes SHALL be inline logic.

Verification
- REQ-037 a=FFFFFFFF, b=00000001, sel=0, op=00001 -> next cycle: result=0, carry=1, zero=1, sign=0.
- REQ-038 Following REQ-037, op=00101, a=2, b=3 -> result=5, carry stays 1, zero=0.
- REQ-039 a=00000001, b=00000024, sel=0, op=01000 -> result=00000010 (left logical by 4; b[5] ignored).
- REQ-040 a=80000000, b=4, op=01011 -> result=F8000000, sign=1; same with op=01010 -> result=08000000.
- REQ-041 sel=1, b=FFFFFFFE, op=00010 -> result=00000001; op=00011 -> result=0, zero=1.
- REQ-042 op=11111 -> result=0, zero=1, carry held; then rst_n pulsed low between edges -> outputs clear immediately without a clock edge.
